dec_bist_ctrl: RTL and testbench

DEC_BIST_CTRL -- requirements
Module: dec_bist_ctrl

---
 rtl/dec_bist_ctrl.sv | 145 ++++++++++++++
 tb/tb_dec_bist_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_bist_ctrl.sv
// Exhaustive self-test sequencer for a 4-to-16 one-hot decoder: walks codes 0..15, compares D
// against the one-hot expectation and accumulates results. Optional capture: DEC_BIST_FIRST_FAIL_EN.
module dec_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        W,
    input  logic [15:0] D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_mask,
    output logic [4:0]  err_count
`ifdef DEC_BIST_FIRST_FAIL_EN
    ,
    output logic        first_fail_valid,
    output logic [3:0]  first_fail_code,
    output logic [15:0] first_fail_data
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // Count value on the final settle cycle; unused when there is no settle phase.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  k;
    logic [3:0]  settle_cnt;
    logic [15:0] expected;
    logic [15:0] mismatch;
    logic        vec_bad;
    logic        sweep_start;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v >= 5'd16) ? 5'd16 : 5'(v + 5'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)
                    state_nxt = S_APPLY;
            end
            S_APPLY: begin
                if (SETTLE_CYCLES == 0)
                    state_nxt = S_CHECK;
                else
                    state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (k == 4'd15)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_APPLY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sweep_start = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign expected    = 16'h0001 << k;
    assign mismatch    = D ^ expected;
    assign vec_bad     = |mismatch;

    // Check stage: results accumulate only on the CHECK cycle of each vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= 4'd0;
            settle_cnt <= 4'd0;
            fail_mask  <= 16'h0000;
            err_count  <= 5'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (sweep_start) begin
                        k          <= 4'd0;
                        settle_cnt <= 4'd0;
                        fail_mask  <= 16'h0000;
                        err_count  <= 5'd0;
                    end
                end
                S_APPLY:  settle_cnt <= 4'd0;
                S_SETTLE: settle_cnt <= 4'(settle_cnt + 4'd1);
                S_CHECK: begin
                    fail_mask <= fail_mask | mismatch;
                    if (vec_bad)
                        err_count <= sat_inc(err_count);
                    if (k != 4'd15)
                        k <= 4'(k + 4'd1);
                end
                default: ;
            endcase
        end
    end

`ifdef DEC_BIST_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_valid <= 1'b0;
            first_fail_code  <= 4'd0;
            first_fail_data  <= 16'h0000;
        end else if (sweep_start) begin
            first_fail_valid <= 1'b0;
            first_fail_code  <= 4'd0;
            first_fail_data  <= 16'h0000;
        end else if ((state == S_CHECK) && vec_bad && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_code  <= k;
            first_fail_data  <= D;
        end
    end
`endif

    assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 5'd0);

    // Stimulus is forced low outside a sweep so the decoder sees code 0 when idle.
    assign {X, Y, Z, W} = busy ? k : 4'b0000;

endmodule

// File: tb/tb_dec_bist_ctrl.sv
// Bench for dec_bist_ctrl: a table-driven decoder model with planted faults and a sweep-level
// reference computing the expected mask, count and first failure from the response table.
module tb_dec_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b;
    logic        xa, ya, za, wa, xb, yb, zb, wb;
    logic [3:0]  code_a, code_b;
    logic [15:0] d_a, d_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] fm_a, fm_b;
    logic [4:0]  ec_a, ec_b;
`ifdef DEC_BIST_FIRST_FAIL_EN
    logic        ffv_a, ffv_b;
    logic [3:0]  ffc_a, ffc_b;
    logic [15:0] ffd_a, ffd_b;
`endif

    logic [15:0] resp_tbl [16];

    assign code_a = {xa, ya, za, wa};
    assign code_b = {xb, yb, zb, wb};
    assign d_a    = resp_tbl[code_a];
    assign d_b    = 16'h0001 << code_b;

    dec_bist_ctrl #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .X(xa), .Y(ya), .Z(za), .W(wa), .D(d_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(fm_a), .err_count(ec_a)
`ifdef DEC_BIST_FIRST_FAIL_EN
        , .first_fail_valid(ffv_a), .first_fail_code(ffc_a), .first_fail_data(ffd_a)
`endif
    );

    dec_bist_ctrl #(.SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .X(xb), .Y(yb), .Z(zb), .W(wb), .D(d_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(fm_b), .err_count(ec_b)
`ifdef DEC_BIST_FIRST_FAIL_EN
        , .first_fail_valid(ffv_b), .first_fail_code(ffc_b), .first_fail_data(ffd_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int codes_q[$];

    // Reference results for one full sweep over the current response table.
    logic [15:0] em;
    logic [4:0]  ec;
    logic        efv;
    logic [3:0]  efc;
    logic [15:0] efd;

    task automatic model();
        logic [15:0] exp_v;
        em = 16'h0000; ec = 5'd0; efv = 1'b0; efc = 4'd0; efd = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            exp_v = 16'h0001 << c;
            em = em | (resp_tbl[c] ^ exp_v);
            if (resp_tbl[c] != exp_v) begin
                ec = ec + 5'd1;
                if (!efv) begin
                    efv = 1'b1; efc = 4'(c); efd = resp_tbl[c];
                end
            end
        end
    endtask

    task automatic set_fault_free();
        for (int c = 0; c < 16; c++) resp_tbl[c] = 16'h0001 << c;
    endtask

    // Number of positions where the recorded busy-cycle codes differ from 0..15 ascending,
    // each held for 'per' cycles (plus any length difference).
    function automatic int code_seq_errs(int per);
        int e = 0;
        if (codes_q.size() != 16 * per) e++;
        for (int i = 0; i < codes_q.size(); i++)
            if (codes_q[i] != i / per) e++;
        return e;
    endfunction

    // Pulse (or hold) start, then record codes while busy until done. lat counts clock
    // edges from the edge that sampled start to the edge after which done is first seen.
    task automatic sweep(input bit use_b, input bit hold);
        codes_q.delete();
        lat = 0;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
        for (int i = 0; i < 300; i++) begin
            if (use_b ? done_b : done_a) return;
            if (use_b ? busy_b : busy_a) codes_q.push_back(int'(use_b ? code_b : code_a));
            @(posedge clk); #1;
            lat++;
        end
        n_tests++; n_fail++;
        $display("FAIL sweep_timeout: done not seen after %0d edges, required within 300", lat);
    endtask

    task automatic check_results_a(input string tag);
        model();
        n_tests++;
        if (done_a !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b want 1", tag, done_a); end
        n_tests++;
        if (fm_a !== em) begin n_fail++; $display("FAIL %s_mask: got %h want %h", tag, fm_a, em); end
        n_tests++;
        if (ec_a !== ec) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", tag, ec_a, ec); end
        n_tests++;
        if (pass_a !== (ec == 5'd0)) begin
            n_fail++; $display("FAIL %s_pass: got %b want %b", tag, pass_a, (ec == 5'd0));
        end
`ifdef DEC_BIST_FIRST_FAIL_EN
        n_tests++;
        if (ffv_a !== efv || (efv && (ffc_a !== efc || ffd_a !== efd))) begin
            n_fail++;
            $display("FAIL %s_first: got v=%b c=%0d d=%h want v=%b c=%0d d=%h",
                     tag, ffv_a, ffc_a, ffd_a, efv, efc, efd);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        set_fault_free();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy_a, done_a, pass_a, fm_a, ec_a, code_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b pass=%b mask=%h cnt=%0d code=%0d want all 0",
                     busy_a, done_a, pass_a, fm_a, ec_a, code_a);
        end
`ifdef DEC_BIST_FIRST_FAIL_EN
        n_tests++;
        if ({ffv_a, ffc_a, ffd_a} !== '0) begin
            n_fail++; $display("FAIL reset_first: got v=%b c=%0d d=%h want 0", ffv_a, ffc_a, ffd_a);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: got busy=%b done=%b want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_fault_free();
        set_fault_free();
        sweep(1'b0, 1'b0);
        n_tests++;
        if (lat != 64) begin n_fail++; $display("FAIL ff_latency: got %0d want 64", lat); end
        n_tests++;
        if (code_seq_errs(4) != 0) begin
            n_fail++; $display("FAIL ff_codes: %0d bad entries of %0d recorded", code_seq_errs(4), codes_q.size());
        end
        check_results_a("fault_free");
        n_tests++;
        if (code_a !== 4'd0) begin n_fail++; $display("FAIL done_code: got %0d want 0", code_a); end
    endtask

    task automatic test_stuck0_d5();
        set_fault_free();
        for (int c = 0; c < 16; c++) resp_tbl[c] = resp_tbl[c] & ~16'h0020;
        sweep(1'b0, 1'b0);
        check_results_a("sa0_d5");
        n_tests++;
        if (fm_a !== 16'h0020 || ec_a !== 5'd1 || pass_a !== 1'b0) begin
            n_fail++; $display("FAIL sa0_literal: got mask=%h cnt=%0d pass=%b want 0020 1 0", fm_a, ec_a, pass_a);
        end
    endtask

    task automatic test_hold_in_done();
        logic [15:0] m0;
        logic [4:0]  c0;
        m0 = fm_a; c0 = ec_a;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (done_a !== 1'b1 || fm_a !== m0 || ec_a !== c0 || code_a !== 4'd0) begin
            n_fail++;
            $display("FAIL done_hold: got done=%b mask=%h cnt=%0d code=%0d want 1 %h %0d 0",
                     done_a, fm_a, ec_a, code_a, m0, c0);
        end
    endtask

    task automatic test_stuck1_d0();
        set_fault_free();
        for (int c = 0; c < 16; c++) resp_tbl[c] = resp_tbl[c] | 16'h0001;
        sweep(1'b0, 1'b0);
        check_results_a("sa1_d0");
        n_tests++;
        if (fm_a !== 16'h0001 || ec_a !== 5'd15) begin
            n_fail++; $display("FAIL sa1_literal: got mask=%h cnt=%0d want 0001 15", fm_a, ec_a);
        end
    endtask

    task automatic test_random_faults();
        logic [15:0] xm;
        for (int it = 0; it < 6; it++) begin
            set_fault_free();
            for (int c = 0; c < 16; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    xm = 16'($urandom);
                    if (xm == 16'h0000) xm = 16'h8000;
                    resp_tbl[c] = resp_tbl[c] ^ xm;
                end
            end
            if (it == 5)
                for (int c = 0; c < 16; c++) resp_tbl[c] = ~(16'h0001 << c);
            sweep(1'b0, 1'b0);
            check_results_a($sformatf("rand%0d", it));
        end
    endtask

    task automatic test_start_held();
        set_fault_free();
        resp_tbl[9] = 16'h0000;
        sweep(1'b0, 1'b1);
        n_tests++;
        if (lat != 64 || code_seq_errs(4) != 0) begin
            n_fail++; $display("FAIL held_no_restart: got latency=%0d bad_codes=%0d want 64 0", lat, code_seq_errs(4));
        end
        check_results_a("held");
        @(posedge clk); #1;
        n_tests++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || code_a !== 4'd0 || ec_a !== 5'd0 || fm_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL done_restart: got busy=%b done=%b code=%0d cnt=%0d mask=%h want 1 0 0 0 0000",
                     busy_a, done_a, code_a, ec_a, fm_a);
        end
        start_a = 1'b0;
        for (int i = 0; i < 100 && !done_a; i++) begin @(posedge clk); #1; end
        check_results_a("restart");
    endtask

    task automatic test_reset_mid_sweep();
        int waited;
        set_fault_free();
        for (int c = 0; c < 16; c++) resp_tbl[c] = resp_tbl[c] & ~16'h0020;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        waited = 0;
        while (!(busy_a && code_a == 4'd7) && waited < 100) begin @(posedge clk); #1; waited++; end
        n_tests++;
        if (waited >= 100) begin n_fail++; $display("FAIL mid_reach_k7: got timeout want code 7"); end
        @(negedge clk); rst = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({busy_a, done_a, pass_a, fm_a, ec_a, code_a} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b done=%b pass=%b mask=%h cnt=%0d code=%0d want all 0",
                     busy_a, done_a, pass_a, fm_a, ec_a, code_a);
        end
        @(negedge clk); rst = 1'b0; start_a = 1'b0;
        set_fault_free();
        sweep(1'b0, 1'b0);
        n_tests++;
        if (lat != 64 || code_seq_errs(4) != 0) begin
            n_fail++; $display("FAIL post_reset_sweep: got latency=%0d bad_codes=%0d want 64 0", lat, code_seq_errs(4));
        end
        check_results_a("post_reset");
    endtask

    task automatic test_settle0();
        sweep(1'b1, 1'b0);
        n_tests++;
        if (lat != 32) begin n_fail++; $display("FAIL s0_latency: got %0d want 32", lat); end
        n_tests++;
        if (code_seq_errs(2) != 0) begin
            n_fail++; $display("FAIL s0_codes: %0d bad entries of %0d recorded", code_seq_errs(2), codes_q.size());
        end
        n_tests++;
        if (pass_b !== 1'b1 || fm_b !== 16'h0000 || ec_b !== 5'd0) begin
            n_fail++; $display("FAIL s0_result: got pass=%b mask=%h cnt=%0d want 1 0000 0", pass_b, fm_b, ec_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fault_free();
        test_stuck0_d5();
        test_hold_in_done();
        test_stuck1_d0();
        test_random_faults();
        test_start_held();
        test_reset_mid_sweep();
        test_settle0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
